// File: rtl/axil_pkg.sv
// axil_pkg: shared constants and elaboration helpers for the axil command path.
//   KEEP_WR / KEEP_RD : tkeep encodings for write and read command beats.
//   clog2()           : ceiling log2, shared with axil_top.
//   byte_wd()         : tkeep width for a {data, addr} beat.
//   arb_state_e       : lock state of the command arbiter.
package axil_pkg;

   localparam logic [1:0] KEEP_WR = 2'b11;
   localparam logic [1:0] KEEP_RD = 2'b01;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } arb_state_e;

   // Ceiling log2; returns 0 for inputs of 0 and 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // One keep bit per byte of the {data, addr} beat.
   function automatic int unsigned byte_wd(input int unsigned addr_wd,
                                           input int unsigned data_wd);
      return (addr_wd + data_wd) >> 3;
   endfunction

endpackage

// File: rtl/axil_cmd_arb_if.sv
// axil_cmd_arb_if: requester-side and axil_top-side AXI-Stream command bus.
//   s_tvalid/s_tready/s_tdata/s_tkeep : NUM_REQ requester lanes, lane i in slice i.
//   m_tvalid/m_tready/m_tdata/m_tkeep/m_tid : arbitrated beat toward axil_top.
//   modport slave  : arbiter view.
//   modport master : requesters plus downstream consumer view.
interface axil_cmd_arb_if
   import axil_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_WD = 8,
   parameter int unsigned ADDR_WD = 8,
   parameter int unsigned BYTE_WD = byte_wd(ADDR_WD, DATA_WD),
   parameter int unsigned ID_WD   = clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0]                   s_tvalid;
   logic [NUM_REQ-1:0]                   s_tready;
   logic [NUM_REQ*(DATA_WD+ADDR_WD)-1:0] s_tdata;
   logic [NUM_REQ*BYTE_WD-1:0]           s_tkeep;

   logic                                 m_tvalid;
   logic                                 m_tready;
   logic [DATA_WD+ADDR_WD-1:0]           m_tdata;
   logic [BYTE_WD-1:0]                   m_tkeep;
   logic [ID_WD-1:0]                     m_tid;

   modport slave (
      input  s_tvalid, s_tdata, s_tkeep, m_tready,
      output s_tready, m_tvalid, m_tdata, m_tkeep, m_tid
   );

   modport master (
      output s_tvalid, s_tdata, s_tkeep, m_tready,
      input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tid
   );

endinterface

// File: rtl/axil_rr_pick.sv
// axil_rr_pick: combinational rotate-priority picker.
//   req_i     : per-requester request vector.
//   last_i    : index granted most recently; search starts just after it.
//   gnt_idx_o : first requesting index found scanning last_i+1, last_i+2, ...
//   gnt_vld_o : high when any request is present.
module axil_rr_pick
   import axil_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_WD   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_WD-1:0]   last_i,
   output logic [ID_WD-1:0]   gnt_idx_o,
   output logic               gnt_vld_o
);

   function automatic logic [ID_WD-1:0] wrap_idx(input int unsigned base,
                                                 input int unsigned off);
      return ID_WD'((base + off) % NUM_REQ);
   endfunction

   // Offset NUM_REQ wraps back to last_i itself, so it has lowest priority.
   always_comb begin
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         if (!gnt_vld_o && req_i[wrap_idx(32'(last_i), k)]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = wrap_idx(32'(last_i), k);
         end
      end
   end

endmodule

// File: rtl/axil_cmd_arb.sv
// axil_cmd_arb: round-robin arbiter with burst locking in front of axil_top.
//   clk  : clock.
//   rstn : synchronous active-low reset.
//   cmd  : axil_cmd_arb_if slave modport; NUM_REQ requester lanes in,
//          one registered, requester-tagged beat out.
module axil_cmd_arb
   import axil_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_WD   = 8,
   parameter int unsigned ADDR_WD   = 8,
   parameter int unsigned BYTE_WD   = byte_wd(ADDR_WD, DATA_WD),
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned ID_WD     = clog2(NUM_REQ)
) (
   input  logic           clk,
   input  logic           rstn,
   axil_cmd_arb_if.slave  cmd
);

   localparam int unsigned PLD_WD  = DATA_WD + ADDR_WD;
   localparam int unsigned BCNT_WD = clog2(MAX_BURST + 1);

   arb_state_e          state_q, state_d;
   logic [ID_WD-1:0]    owner_q, owner_d;
   logic [ID_WD-1:0]    last_q, last_d;
   logic [BCNT_WD-1:0]  bcnt_q, bcnt_d, bcnt_inc;

   logic                m_tvalid_q, m_tvalid_d;
   logic [PLD_WD-1:0]   m_tdata_q, m_tdata_d;
   logic [BYTE_WD-1:0]  m_tkeep_q, m_tkeep_d;
   logic [ID_WD-1:0]    m_tid_q, m_tid_d;

   logic                ld;
   logic                pick_vld;
   logic [ID_WD-1:0]    pick_idx;
   logic                sel_ok;
   logic [ID_WD-1:0]    sel_idx;
   logic [NUM_REQ-1:0]  s_tready_c;
   logic                hs;

   logic [PLD_WD-1:0]   req_data [NUM_REQ];
   logic [BYTE_WD-1:0]  req_keep [NUM_REQ];

   // Split the flat requester buses into per-lane payloads.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign req_data[g] = cmd.s_tdata[g*PLD_WD +: PLD_WD];
      assign req_keep[g] = cmd.s_tkeep[g*BYTE_WD +: BYTE_WD];
   end

   axil_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_WD   (ID_WD)
   ) u_pick (
      .req_i     (cmd.s_tvalid),
      .last_i    (last_q),
      .gnt_idx_o (pick_idx),
      .gnt_vld_o (pick_vld)
   );

   // Grant: a locked owner keeps ready even with valid low, so the drop is seen.
   always_comb begin
      ld         = !m_tvalid_q || cmd.m_tready;
      sel_idx    = (state_q == ST_LOCKED) ? owner_q : pick_idx;
      sel_ok     = (state_q == ST_LOCKED) || pick_vld;
      s_tready_c = '0;
      if (rstn && ld && sel_ok) begin
         s_tready_c[sel_idx] = 1'b1;
      end
      hs = |(s_tready_c & cmd.s_tvalid);
   end

   // Next state for the lock FSM and the one-entry output stage.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      bcnt_d     = bcnt_q;
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tkeep_d  = m_tkeep_q;
      m_tid_d    = m_tid_q;
      bcnt_inc   = bcnt_q + BCNT_WD'(1);

      if (ld) begin
         m_tvalid_d = hs;
         if (hs) begin
            m_tdata_d = req_data[sel_idx];
            m_tkeep_d = req_keep[sel_idx];
            m_tid_d   = sel_idx;
         end
      end

      unique case (state_q)
         ST_UNLOCKED: begin
            if (hs) begin
               owner_d = sel_idx;
               last_d  = sel_idx;
               bcnt_d  = BCNT_WD'(1);
               if (MAX_BURST > 1) begin
                  state_d = ST_LOCKED;
               end
            end
         end
         ST_LOCKED: begin
            if (hs) begin
               bcnt_d = bcnt_inc;
               if (bcnt_inc == BCNT_WD'(MAX_BURST)) begin
                  state_d = ST_UNLOCKED;
               end
            end else if (ld && !cmd.s_tvalid[owner_q]) begin
               state_d = ST_UNLOCKED;
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

   // State and output registers; last resets so the first grant goes to lane 0.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_UNLOCKED;
         owner_q    <= '0;
         last_q     <= ID_WD'(NUM_REQ - 1);
         bcnt_q     <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tid_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         bcnt_q     <= bcnt_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tkeep_q  <= m_tkeep_d;
         m_tid_q    <= m_tid_d;
      end
   end

   assign cmd.s_tready = s_tready_c;
   assign cmd.m_tvalid = m_tvalid_q;
   assign cmd.m_tdata  = m_tdata_q;
   assign cmd.m_tkeep  = m_tkeep_q;
   assign cmd.m_tid    = m_tid_q;

endmodule
